// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  // Address stepping order through the pattern window
  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } seq_mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHOW  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Pattern memory returns data one clock after it samples the address
  localparam int MEM_RD_LATENCY = 1;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Read port between the sequencer (master) and the registered-output pattern memory (slave).
interface led_pattern_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport master (output addr_o, input mem_data_i);
  modport slave  (input addr_o, output mem_data_i);

endinterface

// File: rtl/led_pattern_sequencer_timer.sv
// Hold-period down-counter; o_expire marks the last cycle of the loaded period.
module led_step_timer #(
  parameter int TICK_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [TICK_WIDTH-1:0] i_load_val,
  input  logic                  i_en,
  output logic                  o_expire
);

  localparam logic [TICK_WIDTH-1:0] L_ONE = TICK_WIDTH'(1);

  logic [TICK_WIDTH-1:0] r_count;

  // Load has priority; count never wraps below zero
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - L_ONE;
    end
  end

  assign o_expire = (r_count == L_ONE);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: walks an address window of the pattern memory and
// displays each fetched word for a programmable hold period.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs hold
// S_FETCH | memory samples addr_o
// S_LOAD  | read data valid, captured into led_o on exit
// S_SHOW  | holding pattern for the effective period
// S_DONE  | one-cycle completion pulse
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int TICK_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic                  loop_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  input  logic [TICK_WIDTH-1:0] period_i,
  led_pattern_sequencer_if.master mem,
  output logic [DATA_WIDTH-1:0] led_o,
  output logic                  led_valid_o,
  output logic                  step_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] L_A1 = ADDR_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0] L_T1 = TICK_WIDTH'(1);

  seq_state_t            r_state;
  seq_mode_t             r_mode;
  logic                  r_loop;
  logic                  r_dir_up;
  logic [ADDR_WIDTH-1:0] r_first;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TICK_WIDTH-1:0] r_period;
  logic [DATA_WIDTH-1:0] r_led;
  logic                  r_led_valid;
  logic                  r_step;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_next_dir_up;
  logic                  w_finished;
  logic [TICK_WIDTH-1:0] w_period_eff;
  logic                  w_expire;
  logic                  w_tmr_load;
  logic                  w_tmr_en;

  assign w_period_eff = (period_i == '0) ? L_T1 : period_i;
  assign w_tmr_load   = (r_state == S_LOAD);
  assign w_tmr_en     = (r_state == S_SHOW);

  led_step_timer #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_timer (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (r_period),
    .i_en       (w_tmr_en),
    .o_expire   (w_expire)
  );

  // Next address within [first,last]; w_finished flags the end of one full pass
  always_comb begin
    w_next_addr   = r_addr;
    w_next_dir_up = r_dir_up;
    w_finished    = 1'b0;
    case (r_mode)
      MODE_DOWN: begin
        if (r_addr == r_first) begin
          w_finished  = 1'b1;
          w_next_addr = r_last;
        end else begin
          w_next_addr = r_addr - L_A1;
        end
      end
      MODE_PINGPONG: begin
        if (r_dir_up) begin
          if (r_addr == r_last) begin
            if (r_first == r_last) begin
              w_finished  = 1'b1;
              w_next_addr = r_first;
            end else begin
              w_next_dir_up = 1'b0;
              w_next_addr   = r_addr - L_A1;
            end
          end else begin
            w_next_addr = r_addr + L_A1;
          end
        end else begin
          // Back at the lower endpoint: pass complete, turn upward without repeating it
          if (r_addr == r_first) begin
            w_finished    = 1'b1;
            w_next_dir_up = 1'b1;
            w_next_addr   = r_first + L_A1;
          end else begin
            w_next_addr = r_addr - L_A1;
          end
        end
      end
      default: begin
        if (r_addr == r_last) begin
          w_finished  = 1'b1;
          w_next_addr = r_first;
        end else begin
          w_next_addr = r_addr + L_A1;
        end
      end
    endcase
  end

  // Sequencer FSM with registered outputs; stop overrides everything outside IDLE
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_UP;
      r_loop      <= 1'b0;
      r_dir_up    <= 1'b1;
      r_first     <= '0;
      r_last      <= '0;
      r_addr      <= '0;
      r_period    <= '0;
      r_led       <= '0;
      r_led_valid <= 1'b0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (stop_i && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              if (first_addr_i > last_addr_i) begin
                r_err <= 1'b1;
              end else begin
                r_mode   <= (mode_i == MODE_RSVD) ? MODE_UP : seq_mode_t'(mode_i);
                r_loop   <= loop_i;
                r_first  <= first_addr_i;
                r_last   <= last_addr_i;
                r_period <= w_period_eff;
                r_addr   <= (mode_i == MODE_DOWN) ? last_addr_i : first_addr_i;
                r_dir_up <= (mode_i != MODE_DOWN);
                r_busy   <= 1'b1;
                r_state  <= S_FETCH;
              end
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            r_led       <= mem.mem_data_i;
            r_led_valid <= 1'b1;
            r_step      <= 1'b1;
            r_state     <= S_SHOW;
          end
          S_SHOW: begin
            if (w_expire) begin
              if (w_finished && !r_loop) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_addr   <= w_next_addr;
                r_dir_up <= w_next_dir_up;
                r_state  <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mem.addr_o  = r_addr;
  assign led_o       = r_led;
  assign led_valid_o = r_led_valid;
  assign step_o      = r_step;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a registered-output pattern memory model.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TW = 24;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          loop_i = 1'b0;
  logic [AW-1:0] first_addr_i = '0;
  logic [AW-1:0] last_addr_i = '0;
  logic [TW-1:0] period_i = '0;
  logic [DW-1:0] led_o;
  logic          led_valid_o, step_o, busy_o, done_o, err_o;

  logic [DW-1:0] rom [DEPTH] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_step = 0;
  int done_cnt = 0;
  int d0;

  always #5 sys_clk = ~sys_clk;

  led_pattern_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

  always @(posedge sys_clk) mem_if.mem_data_i <= rom[mem_if.addr_o];

  always @(posedge sys_clk) if (reset && done_o) done_cnt++;

  led_pattern_sequencer #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .TICK_WIDTH (TW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .loop_i       (loop_i),
    .first_addr_i (first_addr_i),
    .last_addr_i  (last_addr_i),
    .period_i     (period_i),
    .mem          (mem_if),
    .led_o        (led_o),
    .led_valid_o  (led_valid_o),
    .step_o       (step_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_if.addr_o), 0);
    chk({tag, "_led"}, 32'(led_o), 0);
    chk({tag, "_valid"}, 32'(led_valid_o), 0);
    chk({tag, "_step"}, 32'(step_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  // Start pulse, then scramble the config inputs to show they were latched
  task automatic start_seq(input int mode, input int lp, input int first, input int last, input int period);
    mode_i       = 2'(mode);
    loop_i       = 1'(lp);
    first_addr_i = AW'(first);
    last_addr_i  = AW'(last);
    period_i     = TW'(period);
    start_i      = 1'b1;
    tick();
    last_step    = cyc;
    mode_i       = ~mode_i;
    loop_i       = ~loop_i;
    first_addr_i = 4'hF;
    last_addr_i  = 4'h0;
    period_i     = TW'(7);
  endtask

  task automatic expect_step(input string tag, input int exp_led, input int exp_addr, input int exp_gap);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!step_o && n < 100);
    chk({tag, "_step"}, 32'(step_o), 1);
    chk({tag, "_led"}, 32'(led_o), exp_led);
    chk({tag, "_addr"}, 32'(mem_if.addr_o), exp_addr);
    chk({tag, "_gap"}, 32'(cyc - last_step), exp_gap);
    last_step = cyc;
  endtask

  task automatic expect_done(input string tag, input int after);
    for (int i = 1; i < after; i++) begin
      tick();
      chk({tag, "_nodone"}, 32'(done_o), 0);
      chk({tag, "_nostep"}, 32'(step_o), 0);
    end
    tick();
    chk({tag, "_done"}, 32'(done_o), 1);
    chk({tag, "_busy_done"}, 32'(busy_o), 1);
    tick();
    chk({tag, "_done_clr"}, 32'(done_o), 0);
    chk({tag, "_busy_clr"}, 32'(busy_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();

    // UP 0..3, period 2, single pass
    d0 = done_cnt;
    start_seq(0, 0, 0, 3, 2);
    chk("t1_busy", 32'(busy_o), 1);
    expect_step("t1_s0", 'h01, 0, 2);
    expect_step("t1_s1", 'h02, 1, 4);
    expect_step("t1_s2", 'h04, 2, 4);
    expect_step("t1_s3", 'h08, 3, 4);
    expect_done("t1", 2);
    chk("t1_led_hold", 32'(led_o), 'h08);
    chk("t1_valid_hold", 32'(led_valid_o), 1);
    chk("t1_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // DOWN 8..11, period 1, looping; a busy start is ignored; stop mid-SHOW
    d0 = done_cnt;
    start_seq(1, 1, 8, 11, 1);
    expect_step("t2_s0", 'hF8, 11, 2);
    expect_step("t2_s1", 'hFC, 10, 3);
    mode_i = 2'd0; first_addr_i = 4'd0; last_addr_i = 4'd1; period_i = TW'(5);
    start_i = 1'b1;
    expect_step("t2_s2", 'hFE, 9, 3);
    expect_step("t2_s3", 'hFF, 8, 3);
    expect_step("t2_s4", 'hF8, 11, 3);
    expect_step("t2_s5", 'hFC, 10, 3);
    stop_i = 1'b1;
    tick();
    chk("t2_stop_busy", 32'(busy_o), 0);
    chk("t2_stop_led", 32'(led_o), 'hFC);
    chk("t2_stop_addr", 32'(mem_if.addr_o), 10);
    repeat (5) tick();
    chk("t2_idle_step", 32'(step_o), 0);
    chk("t2_idle_led", 32'(led_o), 'hFC);
    chk("t2_idle_valid", 32'(led_valid_o), 1);
    chk("t2_no_done", 32'(done_cnt), 32'(d0));

    // PINGPONG 5..7, period 3, single pass
    start_seq(2, 0, 5, 7, 3);
    expect_step("t3_s0", 'h20, 5, 2);
    expect_step("t3_s1", 'h40, 6, 5);
    expect_step("t3_s2", 'h80, 7, 5);
    expect_step("t3_s3", 'h40, 6, 5);
    expect_step("t3_s4", 'h20, 5, 5);
    expect_done("t3", 3);

    // period 0 acts as 1
    start_seq(0, 0, 0, 1, 0);
    expect_step("t4a_s0", 'h01, 0, 2);
    expect_step("t4a_s1", 'h02, 1, 3);
    expect_done("t4a", 1);

    // single-address window
    start_seq(2, 0, 9, 9, 1);
    expect_step("t4b_s0", 'hFE, 9, 2);
    expect_done("t4b", 1);

    // inverted window is rejected
    start_seq(0, 0, 6, 2, 1);
    chk("t4c_err", 32'(err_o), 1);
    chk("t4c_busy", 32'(busy_o), 0);
    tick();
    chk("t4c_err_clr", 32'(err_o), 0);
    chk("t4c_busy_idle", 32'(busy_o), 0);

    // start and stop together from IDLE: stop wins
    mode_i = 2'd0; loop_i = 1'b0; first_addr_i = 4'd0; last_addr_i = 4'd3; period_i = TW'(1);
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    chk("t5a_busy", 32'(busy_o), 0);
    chk("t5a_err", 32'(err_o), 0);
    repeat (3) tick();
    chk("t5a_step", 32'(step_o), 0);
    chk("t5a_busy2", 32'(busy_o), 0);

    // reserved mode runs as UP
    start_seq(3, 0, 12, 13, 1);
    expect_step("t5b_s0", 'hF0, 12, 2);
    expect_step("t5b_s1", 'hE0, 13, 3);
    expect_done("t5b", 1);

    // async reset during SHOW
    start_seq(0, 0, 0, 3, 5);
    expect_step("t6a_s0", 'h01, 0, 2);
    tick();
    #2 reset = 1'b0;
    #1 chk_zero("t6a_rst");
    tick();
    reset = 1'b1;
    start_seq(0, 0, 0, 3, 2);
    expect_step("t6a_r0", 'h01, 0, 2);
    expect_step("t6a_r1", 'h02, 1, 4);
    stop_i = 1'b1;
    tick();
    chk("t6a_stop_busy", 32'(busy_o), 0);

    // async reset during LOAD, pending fetch discarded
    start_seq(0, 0, 4, 5, 1);
    tick();
    chk("t6b_load_busy", 32'(busy_o), 1);
    chk("t6b_load_step", 32'(step_o), 0);
    #2 reset = 1'b0;
    #1 chk_zero("t6b_rst");
    tick();
    reset = 1'b1;
    tick();
    chk("t6b_no_step", 32'(step_o), 0);
    chk("t6b_led", 32'(led_o), 0);
    start_seq(0, 0, 4, 5, 1);
    expect_step("t6b_r0", 'h10, 4, 2);
    expect_step("t6b_r1", 'h20, 5, 3);
    expect_done("t6b", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
